// File: rtl/radix4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | radix4_pkg                                                           |
// | Shared encodings for the radix-4 Booth multiplier family.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package radix4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_CALC = 3'b001,
    ST_DONE = 3'b010
  } state_t;

  localparam logic [2:0] SEL_ZERO = 3'd0;
  localparam logic [2:0] SEL_P1   = 3'd1;
  localparam logic [2:0] SEL_P2   = 3'd2;
  localparam logic [2:0] SEL_M1   = 3'd3;
  localparam logic [2:0] SEL_M2   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/radix4_booth_recode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | radix4_booth_recode                                                  |
// | Maps a 3-bit Booth window {q1,q0,q-1} to a partial-product select.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module radix4_booth_recode
  import radix4_pkg::*;
(
  input  logic [2:0] win,
  output logic [2:0] sel
);

  always_comb begin
    sel = SEL_ZERO;
    case (win)
      3'b001, 3'b010: sel = SEL_P1;
      3'b011:         sel = SEL_P2;
      3'b100:         sel = SEL_M2;
      3'b101, 3'b110: sel = SEL_M1;
      default:        sel = SEL_ZERO;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/radix4_seq_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | radix4_seq_mult                                                      |
// | Sequential signed radix-4 Booth multiplier, one digit per clock.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module radix4_seq_mult
  import radix4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int c_w2    = WIDTH + 2;
  localparam int c_cnt_w = $clog2(WIDTH / 2);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH / 2 - 1);

  // Plain vector rather than state_t so unused codes stay representable.
  logic [2:0]           r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_w2-1:0]      r_a;
  logic [WIDTH-1:0]     r_q;
  logic                 r_qm1;
  logic [WIDTH-1:0]     r_m;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_busy;
  logic                 r_done;

  logic [2:0]           w_sel;
  logic [c_w2-1:0]      w_msx;
  logic [c_w2-1:0]      w_m2x;
  logic [c_w2-1:0]      w_addend;
  logic [c_w2-1:0]      w_a_sum;
  logic [c_w2-1:0]      w_a_shift;
  logic [WIDTH-1:0]     w_q_shift;
  logic                 w_flag;

  radix4_booth_recode u_recode (
    .win ({r_q[1:0], r_qm1}),
    .sel (w_sel)
  );

  // Two guard bits keep -2M exact when M is the most negative value.
  assign w_msx = {{2{r_m[WIDTH-1]}}, r_m};
  assign w_m2x = {w_msx[c_w2-2:0], 1'b0};

  always_comb begin
    w_addend = '0;
    case (w_sel)
      SEL_P1:  w_addend = w_msx;
      SEL_P2:  w_addend = w_m2x;
      SEL_M1:  w_addend = -w_msx;
      SEL_M2:  w_addend = -w_m2x;
      default: w_addend = '0;
    endcase
  end

  assign w_a_sum   = r_a + w_addend;
  assign w_a_shift = {{2{w_a_sum[c_w2-1]}}, w_a_sum[c_w2-1:2]};
  assign w_q_shift = {w_a_sum[1:0], r_q[WIDTH-1:2]};
  assign w_flag    = (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_m       <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (go) begin
            r_a     <= '0;
            r_q     <= multiplier;
            r_qm1   <= 1'b0;
            r_m     <= multiplicand;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_CALC;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          r_a   <= w_a_shift;
          r_q   <= w_q_shift;
          r_qm1 <= r_q[1];
          r_cnt <= r_cnt + c_cnt_w'(1);
          if (w_flag) begin
            r_product <= {w_a_shift[WIDTH-1:0], w_q_shift};
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign product = r_product;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_radix4_seq_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_radix4_seq_mult                                                   |
// | Scoreboard bench for radix4_seq_mult at WIDTH=8.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_radix4_seq_mult;

  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic [15:0] product;
  logic        busy;
  logic        done;

  typedef struct {
    logic [15:0] prod;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          busy_run = 0;
  logic        prev_done = 1'b0;
  logic [15:0] last_exp = '0;

  radix4_seq_mult #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done strobe.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("product", {16'd0, product}, {16'd0, e.prod});
        check("latency", cyc, e.cyc);
        check("busy_len", busy_run, 4);
      end
      check("done_single_pulse", {31'd0, prev_done}, 32'd0);
    end
    check("busy_done_excl", {31'd0, busy & done}, 32'd0);
    busy_run  = busy ? busy_run + 1 : 0;
    prev_done = done;
  end

  // Called at a negedge; the next posedge is the accepting edge.
  task automatic issue(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp);
    exp_t e;
    go           = 1'b1;
    multiplicand = m;
    multiplier   = q;
    e.prod       = exp;
    e.cyc        = cyc + 5;
    sb.push_back(e);
    last_exp     = exp;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic single(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp);
    @(negedge clk);
    issue(m, q, exp);
    @(negedge clk);
    go = 1'b0;
    wait_empty();
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] m, input logic [7:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[15:0];
  endfunction

  logic [7:0]  vm [12] = '{8'd7, 8'h80, 8'h80, 8'd0,  8'hFF, 8'd127, 8'hFB, 8'd100, 8'h80, 8'd1,  8'd13,  8'h80};
  logic [7:0]  vq [12] = '{8'd3, 8'h80, 8'd127, 8'hB3, 8'hFF, 8'd127, 8'd6,  8'hFD,  8'd1,  8'h80, 8'hF3,  8'd0};
  logic [15:0] vp [12] = '{16'h0015, 16'h4000, 16'hC080, 16'h0000, 16'h0001, 16'h3F01,
                           16'hFFE2, 16'hFED4, 16'hFF80, 16'hFF80, 16'hFF57, 16'h0000};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // Directed single operations with a held-value check after each
    for (int i = 0; i < 12; i++) begin
      single(vm[i], vq[i], vp[i]);
      repeat (3) @(negedge clk);
      check("held", {16'd0, product}, {16'd0, last_exp});
    end

    // Back-to-back with go held high; operands scrambled during CALC
    @(negedge clk);
    issue(vm[0], vq[0], vp[0]);
    for (int k = 1; k < 12; k++) begin
      repeat (4) begin
        @(negedge clk);
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
      end
      @(negedge clk);
      issue(vm[k], vq[k], vp[k]);
    end
    repeat (4) @(negedge clk);
    @(negedge clk);
    go = 1'b0;
    wait_empty();

    // go toggled and operands changed while in CALC
    @(negedge clk);
    issue(8'd11, 8'd9, 16'd99);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      go           = (i % 2 == 1);
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
    end
    wait_empty();
    go = 1'b0;
    repeat (3) @(negedge clk);
    check("held_after_toggle", {16'd0, product}, 32'd99);

    // Coarse signed sweep, back-to-back, against a reference multiply
    @(negedge clk);
    for (int mi = -128; mi < 128; mi += 17) begin
      for (int qi = -128; qi < 128; qi += 23) begin
        issue(8'(mi), 8'(qi), ref_mul(8'(mi), 8'(qi)));
        repeat (5) @(negedge clk);
      end
    end
    go = 1'b0;
    wait_empty();

    // Asynchronous reset in the second CALC cycle
    @(negedge clk);
    go           = 1'b1;
    multiplicand = 8'd50;
    multiplier   = 8'd3;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_product", {16'd0, product}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    single(8'd5, 8'hFA, 16'hFFE2);

    // Illegal state code returns to IDLE without a done strobe
    @(negedge clk);
    force dut.r_state = 3'b111;
    @(negedge clk);
    release dut.r_state;
    @(negedge clk);
    check("illegal_state_recover", {29'd0, dut.r_state}, 32'd0);
    check("illegal_state_done", {31'd0, done}, 32'd0);
    check("illegal_state_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/radix4_seq_mult.md
# radix4_seq_mult

Sequential signed radix-4 Booth multiplier: one `go` pulse captures two WIDTH-bit two's-complement operands. The block then retires one Booth digit per clock and presents a 2·WIDTH-bit product with a one-cycle `done` strobe. It contains the datapath and iteration counter that produce the loop-terminal `flag` consumed by the controller's next-state logic, plus the 3-bit state register that closes the loop.

## Interface
- `WIDTH`, default 8, operand width; must be even and ≥4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `go`  in  1  start request; sampled only in IDLE or DONE.
- `multiplicand`  in  WIDTH  signed operand M; sampled on the accepting edge only.
- `multiplier`  in  WIDTH  signed operand Q; sampled on the accepting edge only.
- `product`  out  2·WIDTH  signed M·Q; registered; holds until the next completion.
- `busy`  out  1  high in CALC.
- `done`  out  1  high for exactly one cycle, in DONE.

## Operation
- The states use a 3-bit encoding: IDLE=000, CALC=001, DONE=010. All other codes go to IDLE on the next edge.
- IDLE:
  - `go`=1 → load A=0 (WIDTH+2 bits), Q=multiplier, q₋₁=0, Mreg=multiplicand, cnt=0, state→CALC.
  - Otherwise stay in IDLE.
- CALC, each cycle:
  - Recode {Q[1],Q[0],q₋₁}: 000/111→0; 001/010→+M; 011→+2M; 100→−2M; 101/110→−M.
  - M is sign-extended to WIDTH+2 bits before ±, 2×.
  - A' = A + digit·M, computed modulo 2^(WIDTH+2).
  - Then arithmetic shift {A',Q,q₋₁} right by 2; the sign of A' fills the top.
  - cnt increments.
- `flag` = (cnt == WIDTH/2−1). When `flag` is high in CALC, the shift result is written to `product` = {A[WIDTH−1:0],Q} and state→DONE.
- DONE:
  - `done`=1.
  - `go`=1 → accept a new operation exactly as in IDLE (back-to-back operation).
  - Otherwise state→IDLE.
- `go` in CALC is ignored. Operand changes outside the accepting edge are ignored.
- The result is exact for all inputs, including −2^(WIDTH−1)·−2^(WIDTH−1); the A register needs its 2 guard bits for this.

## Timing
- Reset (async assert, any state): state=IDLE, cnt=0, A=Q=Mreg=0, q₋₁=0, `product`=0, `busy`=0, `done`=0.
- Reset deassertion is synchronized externally. The first accepting edge is the first rising edge with `rst_n`=1.
- `go` is accepted at edge e0. Then:
  - `busy`=1 during cycles e0..e0+WIDTH/2.
  - At edge e0+WIDTH/2, `product` updates and `done` rises.
  - `done` falls at e0+WIDTH/2+1.
- Latency is WIDTH/2 edges from accept to product valid; WIDTH=8 gives 4.
- Back-to-back throughput is one result per WIDTH/2+1 cycles.
- Reset mid-CALC: the operation is discarded, `product` returns to 0, and no `done` is issued.
- `busy` and `done` are never high together.
- `product` changes only on a DONE entry or on reset.

## Structure
- The shared package `radix4_pkg` holds:
  - state encoding constants (ST_IDLE, ST_CALC, ST_DONE);
  - Booth digit select constants (SEL_ZERO, SEL_P1, SEL_P2, SEL_M1, SEL_M2).
- Sub-module `radix4_booth_recode`: combinational, maps a 3-bit window to a select, and is reused by any future parallel variant.
- The top level holds the state register, counter, A/Q/Mreg registers, adder/subtractor and output registers.

## Test plan
- Basic product: WIDTH=8, go with M=7, Q=3 → after 4 edges `product`=21 (0x0015), `done` pulses once, `busy` high for 4 cycles.
- Extreme negative: M=−128, Q=−128 → `product`=16384 (0x4000). M=−128, Q=127 → `product`=−16256 (0xC080).
- Sweep: exhaustive 8-bit M×Q against a signed reference; zero operands give 0. Check the held value between operations.
- `go` handling:
  - Hold `go`=1 continuously: a result every 5 cycles, each operand pair captured only on DONE/IDLE edges.
  - Toggle `go` and change operands in CALC: no effect.
- Reset mid-operation: assert `rst_n`=0 asynchronously in the 2nd CALC cycle → all outputs 0 immediately. After release, the next go (M=5, Q=−6) → `product`=−30.
- Illegal state: force the state to 111 → IDLE on the next edge, with no `done`.
